lbm_step_sequencer: RTL

//  Upstream controller for the LBM time-step counter: sequences each simulation time step as a

---
 rtl/lbm_pkg.sv | 29 ++
 rtl/lbm_node_scanner.sv | 64 ++++++
 rtl/lbm_step_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lbm_pkg.sv
`default_nettype none
// lbm_pkg: shared LBM sequencer types, lattice defaults and boundary helper.
package lbm_pkg;

  typedef enum logic {
    PH_COLLIDE = 1'b0,
    PH_STREAM  = 1'b1
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLIDE = 3'd1,
    ST_DRAIN_C = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DRAIN_S = 3'd4,
    ST_STEP    = 3'd5,
    ST_DONE    = 3'd6
  } seq_state_t;

  localparam int LBM_NX       = 64;
  localparam int LBM_NY       = 32;
  localparam int LBM_MAX_TIME = 100;

  function automatic logic is_boundary(input int x, input int y, input int nx, input int ny);
    return (x == 0) || (x == nx - 1) || (y == 0) || (y == ny - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lbm_node_scanner.sv
`default_nettype none
// lbm_node_scanner: raster x/y lattice counter, x fastest; shared by both sweep phases.
// With LBM_BOUNDARY_FLAG_EN the next-cycle coordinates are also exported.
module lbm_node_scanner #(
  parameter int NX = 4,
  parameter int NY = 2,
  localparam int X_W = $clog2(NX),
  localparam int Y_W = $clog2(NY)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           clr,
  input  logic           adv,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
`ifdef LBM_BOUNDARY_FLAG_EN
  output logic [X_W-1:0] x_nxt,
  output logic [Y_W-1:0] y_nxt,
`endif
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(NX - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(NY - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_MAX) && (y_q == Y_MAX);
`ifdef LBM_BOUNDARY_FLAG_EN
  assign x_nxt = x_d;
  assign y_nxt = y_d;
`endif

endmodule
`default_nettype wire

// File: rtl/lbm_step_sequencer.sv
`default_nettype none
// lbm_step_sequencer: per time step, a COLLIDE raster sweep then a STREAM sweep, then a step_inc pulse.
// Define LBM_BOUNDARY_FLAG_EN to add the registered node_boundary output.
module lbm_step_sequencer
  import lbm_pkg::*;
#(
  parameter int NX               = LBM_NX,
  parameter int NY               = LBM_NY,
  parameter int MAX_TIME         = LBM_MAX_TIME,
  parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
  localparam int X_W = $clog2(NX),
  localparam int Y_W = $clog2(NY)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      start,
  input  logic [TIME_COUNT_WIDTH:0] time_count,
  input  logic                      pipe_idle,
  input  logic                      node_ready,
  output logic                      node_valid,
  output logic [X_W-1:0]            node_x,
  output logic [Y_W-1:0]            node_y,
  output phase_t                    phase,
  output logic                      step_inc,
  output logic                      busy,
  output logic                      done
`ifdef LBM_BOUNDARY_FLAG_EN
  ,
  output logic                      node_boundary
`endif
);

  localparam logic [TIME_COUNT_WIDTH:0] TC_MAX  = (TIME_COUNT_WIDTH + 1)'(MAX_TIME);
  localparam logic [TIME_COUNT_WIDTH:0] TC_LAST = (TIME_COUNT_WIDTH + 1)'(MAX_TIME - 1);

  seq_state_t state_q, state_d;
  phase_t     phase_q, phase_d;
  logic       node_valid_q, node_valid_d;
  logic       step_inc_q, step_inc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       scan_clr, scan_adv, scan_last, xfer;

`ifdef LBM_BOUNDARY_FLAG_EN
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           node_boundary_q, node_boundary_d;
`endif

  lbm_node_scanner #(
    .NX(NX),
    .NY(NY)
  ) u_scanner (
    .Clk  (Clk),
    .Reset(Reset),
    .clr  (scan_clr),
    .adv  (scan_adv),
    .x    (node_x),
    .y    (node_y),
`ifdef LBM_BOUNDARY_FLAG_EN
    .x_nxt(x_nxt),
    .y_nxt(y_nxt),
`endif
    .last (scan_last)
  );

  assign xfer = node_valid_q && node_ready;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    scan_clr = 1'b0;
    scan_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          scan_clr = 1'b1;
          if (time_count == TC_MAX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLIDE;
            phase_d = PH_COLLIDE;
          end
        end
      end
      ST_COLLIDE, ST_STREAM: begin
        // The final transfer wraps the scanner back to (0,0) on its own.
        if (xfer) begin
          scan_adv = 1'b1;
          if (scan_last) state_d = (state_q == ST_COLLIDE) ? ST_DRAIN_C : ST_DRAIN_S;
        end
      end
      ST_DRAIN_C: begin
        if (pipe_idle) begin
          state_d = ST_STREAM;
          phase_d = PH_STREAM;
        end
      end
      ST_DRAIN_S: begin
        if (pipe_idle) state_d = ST_STEP;
      end
      ST_STEP: begin
        // time_count has not yet absorbed this step's increment.
        if (time_count == TC_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COLLIDE;
          phase_d = PH_COLLIDE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    node_valid_d = (state_d == ST_COLLIDE) || (state_d == ST_STREAM);
    step_inc_d   = (state_d == ST_STEP);
    busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
`ifdef LBM_BOUNDARY_FLAG_EN
    node_boundary_d = node_valid_d && is_boundary(int'(x_nxt), int'(y_nxt), NX, NY);
`endif
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_COLLIDE;
      node_valid_q <= 1'b0;
      step_inc_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      node_valid_q <= node_valid_d;
      step_inc_q   <= step_inc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef LBM_BOUNDARY_FLAG_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) node_boundary_q <= 1'b0;
    else        node_boundary_q <= node_boundary_d;
  end
  assign node_boundary = node_boundary_q;
`endif

  assign node_valid = node_valid_q;
  assign phase      = phase_q;
  assign step_inc   = step_inc_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire
